mips32_mem_responder: RTL
=========================

# mips32_mem_responder

- Word-addressed memory responder serving the MIPS32 pipeline's two memory initiators: the IF stage (instruction fetch) and the MEM stage (LW/SW).
- Holds a single-ported DEPTH×32 array and arbitrates between a fetch port and a data port.
- Each transaction completes through a req/ack handshake with a programmable number of wait states.
- Sits between the pipeline core and the instruction/data storage; lets the core run against realistic, non-zero-latency memory.

## Interface

Parameters:
- DEPTH, 1024, number of 32-bit words.
- AW, 10, address bits used to index the array (log2 DEPTH).
- WAIT_CYCLES, 1, wait states per access, legal range 0..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  32  fetch word address (PC).
- if_rdata  output  32  fetched instruction; valid while if_ack=1.
- if_ack  output  1  one-cycle fetch completion pulse.
- dm_req  input  1  data request; held until dm_ack.
- dm_we  input  1  1 = store (SW), 0 = load (LW).
- dm_addr  input  32  data word address (ALUOut).
- dm_wdata  input  32  store data.
- dm_rdata  output  32  load data; valid while dm_ack=1.
- dm_ack  output  1  one-cycle data completion pulse.

## Operation

FSM states: IDLE, BUSY, RESP.

**IDLE**
- If any request is pending, grant one port and latch that port's addr, we and wdata, plus the granted source.
- Load wait_cnt with WAIT_CYCLES.
- Go to BUSY, or straight to RESP when WAIT_CYCLES = 0.
- Arbitration when only one request is pending: grant that port.
- Arbitration when both are pending: grant the port not granted last (last_grant register). Reset value of last_grant is IF, so the first tie goes to data.

**BUSY**
- Decrement wait_cnt each cycle.
- On the edge where wait_cnt = 1, perform the access and go to RESP.

**RESP**
- Assert the granted port's ack for exactly one cycle.
- Return to IDLE.

**Access rules**
- Address in range (addr[31:AW] = 0):
  - Read: registers mem[addr[AW-1:0]] into that port's rdata.
  - Write: stores wdata; dm_rdata is left unchanged.
- Address out of range (addr[31:AW] ≠ 0):
  - Read returns 32'h0.
  - Write is dropped.
  - Ack is still given.
- Request inputs are sampled only in IDLE. Deasserting req after the grant does not cancel the transaction; the ack pulse is still produced.
- A write followed by a read of the same address returns the new data.
- The array is not reset.
- Reset mid-operation: the FSM returns to IDLE, and no ack is issued for the abandoned transaction. A write not yet performed (state still BUSY) never reaches the array.

**Reset values**
- State IDLE, wait_cnt 0, last_grant IF.
- if_ack 0, dm_ack 0, if_rdata 0, dm_rdata 0.

## Timing

- A request seen in IDLE in cycle c produces ack in cycle c+WAIT_CYCLES+1.
- Read data is valid in that same cycle.
- Throughput is one transaction per WAIT_CYCLES+2 cycles, because each transaction passes through one IDLE cycle.
- Ack and rdata are registered outputs; there is no combinational path from inputs to outputs.
- The initiator must drop req, or present its next request, in the cycle after ack. The next IDLE cycle samples the updated inputs.
- if_ack and dm_ack are never high together.

## Configuration

- Macro: MEM_PRELOAD_EN.
- With the macro defined:
  - Adds ports ld_we (input, 1), ld_addr (input, AW) and ld_wdata (input, 32), used for program loading.
  - ld_we=1 writes mem[ld_addr] on the rising edge, independent of FSM state.
  - While ld_we=1, IDLE accepts no new requests.
  - If a preload write and an FSM write hit the same word on the same edge, the preload write wins.
- Without the macro: these ports are absent, and the array is written only through dm stores.

## Test plan

1. WAIT_CYCLES=1: dm store of 0xDEADBEEF to addr 5, then dm load of addr 5.
   - dm_ack arrives 2 cycles after each request is sampled.
   - The load returns dm_rdata = 0xDEADBEEF.
2. if_req and dm_req rise together just after reset, both held.
   - dm_ack comes first.
   - if_ack follows WAIT_CYCLES+2 cycles later.
   - The acks never overlap.
3. Both ports requesting continuously for 8 transactions.
   - Grants alternate D, I, D, I, …
   - Each port completes 4 transactions.
4. dm store to addr 0x400, then load of addr 0x400.
   - Both are acked.
   - The load returns 0.
   - mem[0] is unchanged (verified by a fetch of addr 0).
5. rst_n pulsed low during BUSY of a store to addr 7 (old value 0x11).
   - No dm_ack is issued.
   - A subsequent load of addr 7 returns 0x11.
6. WAIT_CYCLES=0: fetch request in cycle c.
   - if_ack is high in cycle c+1 with the correct instruction.
   - With MEM_PRELOAD_EN defined, a word preloaded via ld_we is returned by this fetch.

Source files
------------

// File: rtl/mips32_mem_if.sv
// Request/acknowledge bus between the MIPS32 pipeline (master) and its memory responder (slave).
// The IF port carries instruction fetches and the DM port carries LW/SW accesses.
interface mips32_mem_if;
  // Handshake: the master raises *_req with a stable address (and store data for DM)
  // and holds it until *_ack. *_ack is a one-cycle pulse, and *_rdata is valid only while it is high.
  // In the cycle after ack, the master drops req or presents its next request.
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output if_rdata, if_ack, dm_rdata, dm_ack
  );
endinterface

// File: rtl/mips32_mem_responder.sv
// Single-ported DEPTH x 32 memory that serves the IF and DM ports with WAIT_CYCLES wait states.
// Define MEM_PRELOAD_EN to add the ld_* program-load write port.
module mips32_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mips32_mem_if.slave       bus,
  output logic [1:0]        dbg_state
`ifdef MEM_PRELOAD_EN
  ,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [31:0]       ld_wdata
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DM = 1'b1;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        last_grant;
  logic        src_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic        accept_block;
  logic        any_req;
  logic        grant_dm;
  logic        grant_we;
  logic [31:0] grant_addr;

  logic        acc_fire;
  logic        acc_src;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_in_range;
  logic [AW-1:0] acc_idx;
  logic        mem_we;
  logic [31:0] rd_word;

`ifdef MEM_PRELOAD_EN
  assign accept_block = ld_we;
`else
  assign accept_block = 1'b0;
`endif

  assign dbg_state = state;

  // On a tie, the port that lost the last arbitration gets the grant.
  always_comb begin
    any_req    = (bus.if_req | bus.dm_req) & ~accept_block;
    grant_dm   = bus.dm_req & (~bus.if_req | (last_grant == SRC_IF));
    grant_addr = grant_dm ? bus.dm_addr : bus.if_addr;
    grant_we   = grant_dm & bus.dm_we;
  end

  // With zero wait states, the access happens on the same edge as the grant, so it uses the live inputs.
  always_comb begin
    acc_fire  = 1'b0;
    acc_src   = src_q;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE && any_req && WAIT_CYCLES == 0) begin
      acc_fire  = 1'b1;
      acc_src   = grant_dm;
      acc_we    = grant_we;
      acc_addr  = grant_addr;
      acc_wdata = bus.dm_wdata;
    end else if (state == BUSY && wait_cnt == 8'd1) begin
      acc_fire = 1'b1;
    end
    acc_fire     = acc_fire & rst_n;
    acc_in_range = (acc_addr[31:AW] == '0);
    acc_idx      = acc_addr[AW-1:0];
    mem_we       = acc_fire & acc_we & acc_in_range;
    rd_word      = acc_in_range ? mem[acc_idx] : 32'h0;
  end

  // The array is not reset. The preload write comes last, so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
`ifdef MEM_PRELOAD_EN
    if (ld_we) mem[ld_addr] <= ld_wdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      last_grant   <= SRC_IF;
      src_q        <= SRC_IF;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      bus.if_ack   <= 1'b0;
      bus.dm_ack   <= 1'b0;
      bus.if_rdata <= 32'h0;
      bus.dm_rdata <= 32'h0;
    end else begin
      bus.if_ack <= acc_fire & (acc_src == SRC_IF);
      bus.dm_ack <= acc_fire & (acc_src == SRC_DM);
      if (acc_fire && !acc_we) begin
        if (acc_src == SRC_DM) bus.dm_rdata <= rd_word;
        else                   bus.if_rdata <= rd_word;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            src_q      <= grant_dm;
            last_grant <= grant_dm;
            we_q       <= grant_we;
            addr_q     <= grant_addr;
            wdata_q    <= bus.dm_wdata;
            wait_cnt   <= WAIT_INIT;
            state      <= (WAIT_CYCLES == 0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
